fp16_result_drain: RTL and testbench

FP16_RESULT_DRAIN -- requirements
Module: fp16_result_drain

---
 rtl/fp16_result_drain.sv | 214 +++++++++++++++++++++
 tb/tb_fp16_result_drain.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_result_drain.sv
// fp16_result_drain: collects one N x N FP16 result tile from a systolic array
// and streams it out row by row over a valid/ready interface.
//
// After an accepted start the block waits k_len+LAT cycles for the array to
// fill and flush, snapshots the whole result bus into a local register bank,
// then emits rows 0..N-1 in order, followed by a one-cycle done pulse.
//
// Parameters
//   N    array dimension (N x N FP16 results)
//   LAT  array fill/flush latency added to the accumulation length (<= 256)
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   start        one-cycle request to collect a tile (honoured only in IDLE)
//   k_len        accumulation step count, sampled with start
//   c_bus        array result bus, element (i,j) at [(i*N+j+1)*16-1 -: 16]
//   out_ready    downstream ready
//   out_valid    out_data carries a valid row
//   out_data     one row, element j at [(j+1)*16-1 -: 16]
//   out_row      index of the row on out_data
//   out_last     out_valid for row N-1
//   busy         high whenever the FSM is not IDLE
//   done         one-cycle pulse after the last row transfers
//   special_flag (FP16_DRAIN_SPECIAL_FLAG_EN only) a captured element had
//                an all-ones exponent (Inf/NaN)
//
// Optional feature macro: FP16_DRAIN_SPECIAL_FLAG_EN

module fp16_result_drain #(
   parameter int unsigned N   = 16,
   parameter int unsigned LAT = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [7:0]             k_len,
   input  logic [16*N*N-1:0]      c_bus,
   input  logic                   out_ready,
   output logic                   out_valid,
   output logic [16*N-1:0]        out_data,
   output logic [$clog2(N)-1:0]   out_row,
   output logic                   out_last,
   output logic                   busy,
   output logic                   done
`ifdef FP16_DRAIN_SPECIAL_FLAG_EN
   ,
   output logic                   special_flag
`endif
);

   localparam int unsigned ELEM_W = 16;
   localparam int unsigned ROW_W  = ELEM_W * N;
   localparam int unsigned BANK_W = ROW_W * N;
   localparam int unsigned IDX_W  = $clog2(N);
   localparam int unsigned CNT_W  = 9;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [BANK_W-1:0]   bank_q, bank_d;
   logic                out_valid_q, out_valid_d;
   logic [ROW_W-1:0]    out_data_q, out_data_d;
   logic [IDX_W-1:0]    out_row_q, out_row_d;
   logic                out_last_q, out_last_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [IDX_W-1:0]    next_row;
   logic                row_is_last;

`ifdef FP16_DRAIN_SPECIAL_FLAG_EN
   logic                flag_q, flag_d;
   logic                any_special;

   // An FP16 exponent of all ones marks Inf or NaN anywhere on the bus.
   always_comb begin
      any_special = 1'b0;
      for (int unsigned e = 0; e < N * N; e++) begin
         if (c_bus[e*ELEM_W + 10 +: 5] == 5'h1F) begin
            any_special = 1'b1;
         end
      end
   end
`endif

   // Row r of a bank laid out row-major, element 0 in the low bits.
   function automatic logic [ROW_W-1:0] row_of(input logic [BANK_W-1:0] bank,
                                               input logic [IDX_W-1:0]  idx);
      return bank[int'(idx)*ROW_W +: ROW_W];
   endfunction

   assign next_row    = IDX_W'(out_row_q + 1'b1);
   assign row_is_last = (out_row_q == IDX_W'(N - 1));

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bank_d      = bank_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_row_d   = out_row_q;
      out_last_d  = out_last_q;
      done_d      = 1'b0;
`ifdef FP16_DRAIN_SPECIAL_FLAG_EN
      flag_d      = flag_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (start) begin
               // The counter carries k_len forward; reaching zero after
               // k_len+LAT edges lines up with the snapshot.
               cnt_d   = CNT_W'(k_len) + CNT_W'(LAT - 1);
               state_d = WAIT;
`ifdef FP16_DRAIN_SPECIAL_FLAG_EN
               flag_d  = 1'b0;
`endif
            end
         end

         WAIT: begin
            if (cnt_q == '0) begin
               bank_d      = c_bus;
               state_d     = STREAM;
               out_valid_d = 1'b1;
               out_row_d   = '0;
               out_data_d  = c_bus[ROW_W-1:0];
               out_last_d  = (N == 1);
`ifdef FP16_DRAIN_SPECIAL_FLAG_EN
               flag_d      = any_special;
`endif
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         STREAM: begin
            if (out_ready) begin
               if (row_is_last) begin
                  state_d     = DONE;
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  out_row_d   = '0;
                  out_data_d  = '0;
                  done_d      = 1'b1;
               end else begin
                  out_row_d  = next_row;
                  out_data_d = row_of(bank_q, next_row);
                  out_last_d = (next_row == IDX_W'(N - 1));
               end
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bank_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_row_q   <= '0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef FP16_DRAIN_SPECIAL_FLAG_EN
         flag_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bank_q      <= bank_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_row_q   <= out_row_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
`ifdef FP16_DRAIN_SPECIAL_FLAG_EN
         flag_q      <= flag_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_row   = out_row_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;
   assign done      = done_q;
`ifdef FP16_DRAIN_SPECIAL_FLAG_EN
   assign special_flag = flag_q;
`endif

endmodule

// File: tb/tb_fp16_result_drain.sv
// Testbench for fp16_result_drain with N=4, LAT=8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fp16_result_drain;

   localparam int N   = 4;
   localparam int LAT = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [7:0]        k_len;
   logic [16*N*N-1:0] c_bus;
   logic              out_ready;
   logic              out_valid;
   logic [16*N-1:0]   out_data;
   logic [1:0]        out_row;
   logic              out_last;
   logic              busy;
   logic              done;
`ifdef FP16_DRAIN_SPECIAL_FLAG_EN
   logic              special_flag;
`endif

   int total = 0;
   int bad   = 0;

   fp16_result_drain #(.N(N), .LAT(LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .k_len     (k_len),
      .c_bus     (c_bus),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_row   (out_row),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
`ifdef FP16_DRAIN_SPECIAL_FLAG_EN
      ,
      .special_flag (special_flag)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int             k;
      logic [255:0]   cb;
      int             stall_row;
      int             stall_len;
      bit             chg;
      bit             extra;
      int             exp_lat;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: row r of the tile as laid out on the bus.
   function automatic logic [63:0] mrow(input logic [255:0] cb, input int r);
      return cb[r*64 +: 64];
   endfunction

   // Reference: any element with exponent 5'h1F.
   function automatic bit mspec(input logic [255:0] cb);
      for (int e = 0; e < N*N; e++) begin
         if (cb[e*16+10 +: 5] == 5'h1F) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic logic [255:0] pat(input logic [15:0] base);
      logic [255:0] cb;
      for (int e = 0; e < N*N; e++) cb[e*16 +: 16] = base + 16'(e);
      return cb;
   endfunction

   function automatic logic [255:0] rnd_bus();
      logic [255:0] cb;
      for (int w = 0; w < 8; w++) cb[w*32 +: 32] = $urandom;
      return cb;
   endfunction

   function automatic vec_t mkv(input int k, input logic [255:0] cb, input int sr,
                                input int sl, input bit chg, input bit extra, input int lat);
      vec_t v;
      v.k = k; v.cb = cb; v.stall_row = sr; v.stall_len = sl;
      v.chg = chg; v.extra = extra; v.exp_lat = lat;
      return v;
   endfunction

   // Run one tile from IDLE; called at a falling edge.
   task automatic run_tile(input vec_t v);
      int           cyc;
      logic [255:0] snap;
      snap      = v.cb;
      c_bus     = v.cb;
      k_len     = 8'(v.k);
      start     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc   = 0;
      chk("busy_in_wait", 64'(busy), 64'd1);
      while (!out_valid && cyc < 600) begin
         start = v.extra && (cyc == 2);
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      chk("snapshot_latency", 64'(cyc), 64'(v.exp_lat));
      if (v.chg) c_bus = '1;
`ifdef FP16_DRAIN_SPECIAL_FLAG_EN
      chk("special_flag_set", 64'(special_flag), 64'(mspec(snap)));
`endif
      for (int r = 0; r < N; r++) begin
         chk("row_valid", 64'(out_valid), 64'd1);
         chk("row_index", 64'(out_row), 64'(r));
         chk("row_data",  out_data, mrow(snap, r));
         chk("row_last",  64'(out_last), 64'(r == N-1));
         chk("row_busy",  64'(busy), 64'd1);
         if (r == v.stall_row) begin
            for (int s = 0; s < v.stall_len; s++) begin
               out_ready = 1'b0;
               @(negedge clk);
               chk("stall_valid", 64'(out_valid), 64'd1);
               chk("stall_row",   64'(out_row), 64'(r));
               chk("stall_data",  out_data, mrow(snap, r));
            end
         end
         out_ready = 1'b1;
         @(negedge clk);
      end
      chk("done_pulse",  64'(done), 64'd1);
      chk("done_busy",   64'(busy), 64'd1);
      chk("done_nvalid", 64'(out_valid), 64'd0);
      start = v.extra;
      k_len = 8'd3;
      @(negedge clk);
      start = 1'b0;
      chk("done_cleared", 64'(done), 64'd0);
      chk("idle_busy",    64'(busy), 64'd0);
      @(negedge clk);
      chk("idle_stays",   64'(busy), 64'd0);
      chk("idle_nvalid",  64'(out_valid), 64'd0);
`ifdef FP16_DRAIN_SPECIAL_FLAG_EN
      chk("special_flag_held", 64'(special_flag), 64'(mspec(snap)));
`endif
   endtask

   vec_t tbl[6];

   initial begin
      logic [255:0] sp;
      int           cyc;
      int           k;
      sp = pat(16'h3C00);
      sp[11*16 +: 16] = 16'h7C00;
      tbl[0] = mkv(4,   pat(16'h3C00), -1, 0, 1'b0, 1'b0, 12);
      tbl[1] = mkv(0,   pat(16'h4000), -1, 0, 1'b0, 1'b0, 8);
      tbl[2] = mkv(4,   pat(16'h3C00),  1, 5, 1'b1, 1'b0, 12);
      tbl[3] = mkv(3,   pat(16'h1234), -1, 0, 1'b0, 1'b1, 11);
      tbl[4] = mkv(255, pat(16'h0100),  3, 2, 1'b1, 1'b0, 263);
      tbl[5] = mkv(1,   sp,             0, 1, 1'b0, 1'b0, 9);

      rst = 1'b1; start = 1'b0; out_ready = 1'b0; k_len = '0; c_bus = '0;
      repeat (2) @(negedge clk);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_last",  64'(out_last), 64'd0);
      chk("rst_busy",  64'(busy), 64'd0);
      chk("rst_done",  64'(done), 64'd0);
      chk("rst_row",   64'(out_row), 64'd0);
      chk("rst_data",  out_data, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 6; i++) run_tile(tbl[i]);

      // Reset in the middle of streaming, after row 2 transfers.
      c_bus = pat(16'h2000); k_len = 8'd1; start = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0; cyc = 0;
      while (!out_valid && cyc < 600) begin @(negedge clk); cyc++; end
      chk("mid_rst_latency", 64'(cyc), 64'(1 + LAT));
      repeat (3) @(negedge clk);
      chk("mid_rst_row3", 64'(out_row), 64'd3);
      out_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_busy",  64'(busy), 64'd0);
      chk("mid_rst_done",  64'(done), 64'd0);
      chk("mid_rst_row",   64'(out_row), 64'd0);
      chk("mid_rst_data",  out_data, 64'd0);
      chk("mid_rst_last",  64'(out_last), 64'd0);
      @(negedge clk);
      chk("mid_rst_nodone", 64'(done), 64'd0);

      // Start coincident with reset is dropped.
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("start_with_rst", 64'(busy), 64'd0);

      run_tile(mkv(2, pat(16'h5000), -1, 0, 1'b0, 1'b0, 2 + LAT));

      // Randomized tiles against the model.
      for (int i = 0; i < 8; i++) begin
         k = int'($urandom_range(0, 30));
         run_tile(mkv(k, rnd_bus(), int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), k + LAT));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
